// File: rtl/ray_sched_pkg.sv
// Shared types and widths for the ray pixel scheduler.
package ray_sched_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLatch,
    StScan,
    StDrain
  } sched_state_t;

  localparam int unsigned H_PIXELS_DEFAULT = 1024;
  localparam int unsigned V_PIXELS_DEFAULT = 768;

  localparam int unsigned X_W  = 11;
  localparam int unsigned Y_W  = 10;

  localparam int unsigned BX_W = 12;
  localparam int unsigned BY_W = 12;
  localparam int unsigned BZ_W = 14;

endpackage

// File: rtl/ray_pixel_scheduler_raster_counter.sv
// Raster-order x/y counter: x runs fastest, wraps into y, and returns to (0,0) after the
// last pixel. last_out flags (H_PIXELS-1, V_PIXELS-1).
module raster_counter
  import ray_sched_pkg::*;
#(
  parameter int unsigned H_PIXELS = H_PIXELS_DEFAULT,
  parameter int unsigned V_PIXELS = V_PIXELS_DEFAULT
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           clear_in,
  input  logic           advance_in,
  output logic [X_W-1:0] x_out,
  output logic [Y_W-1:0] y_out,
  output logic           last_out
);

  logic [X_W-1:0] x_q;
  logic [Y_W-1:0] y_q;
  logic           x_wrap;

  assign x_wrap   = (x_q == X_W'(H_PIXELS - 1));
  assign last_out = x_wrap && (y_q == Y_W'(V_PIXELS - 1));
  assign x_out    = x_q;
  assign y_out    = y_q;

  always_ff @(posedge clk_in) begin
    if (rst_in || clear_in) begin
      x_q <= '0;
      y_q <= '0;
    end else if (advance_in) begin
      if (last_out) begin
        x_q <= '0;
        y_q <= '0;
      end else if (x_wrap) begin
        x_q <= '0;
        y_q <= y_q + Y_W'(1);
      end else begin
        x_q <= x_q + X_W'(1);
      end
    end
  end

endmodule

// File: rtl/ray_pixel_scheduler.sv
// Frame sequencer: snapshots block positions, issues pixels in raster order under credit
// control, and pulses frame_done_out once all results are drained. Optional feature:
// RAY_SCHED_STALL_COUNT_EN enables the credit-stall cycle counter.
module ray_pixel_scheduler
  import ray_sched_pkg::*;
#(
  parameter int unsigned H_PIXELS     = H_PIXELS_DEFAULT,
  parameter int unsigned V_PIXELS     = V_PIXELS_DEFAULT,
  parameter int unsigned NUM_BLOCKS   = 12,
  parameter int unsigned MAX_INFLIGHT = 64
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic                             frame_start_in,
  input  logic [NUM_BLOCKS-1:0][BX_W-1:0]  block_x_live_in,
  input  logic [NUM_BLOCKS-1:0][BY_W-1:0]  block_y_live_in,
  input  logic [NUM_BLOCKS-1:0][BZ_W-1:0]  block_z_live_in,
  input  logic                             credit_return_in,
  output logic [X_W-1:0]                   x_out,
  output logic [Y_W-1:0]                   y_out,
  output logic                             valid_out,
  output logic [NUM_BLOCKS-1:0][BX_W-1:0]  block_x_out,
  output logic [NUM_BLOCKS-1:0][BY_W-1:0]  block_y_out,
  output logic [NUM_BLOCKS-1:0][BZ_W-1:0]  block_z_out,
  output logic                             busy_out,
  output logic                             frame_done_out,
  output logic [31:0]                      stall_cycles_out
);

  localparam int unsigned IW = $clog2(MAX_INFLIGHT + 1);

  sched_state_t state_q;
  logic [IW-1:0] inflight_q, inflight_d;

  logic [X_W-1:0] x_q;
  logic [Y_W-1:0] y_q;
  logic           valid_q;
  logic           busy_q;
  logic           done_q;

  logic [NUM_BLOCKS-1:0][BX_W-1:0] snap_x_q;
  logic [NUM_BLOCKS-1:0][BY_W-1:0] snap_y_q;
  logic [NUM_BLOCKS-1:0][BZ_W-1:0] snap_z_q;

  logic [X_W-1:0] rc_x;
  logic [Y_W-1:0] rc_y;
  logic           rc_last;
  logic           rc_clear;

  logic active;
  logic issue;
  logic ret_ok;

  // Pixel (0,0) is decided in LATCH so that its strobe lands together with the snapshot.
  assign active   = (state_q == StLatch) || (state_q == StScan);
  // A return in this cycle frees a credit for this cycle's issue decision.
  assign issue    = active && ((inflight_q < IW'(MAX_INFLIGHT)) || credit_return_in);
  assign ret_ok   = credit_return_in && (inflight_q != '0);
  assign rc_clear = (state_q == StIdle) && frame_start_in;

  always_comb begin
    inflight_d = inflight_q;
    if (issue && !ret_ok) begin
      inflight_d = inflight_q + IW'(1);
    end else if (!issue && ret_ok) begin
      inflight_d = inflight_q - IW'(1);
    end
  end

  raster_counter #(
    .H_PIXELS (H_PIXELS),
    .V_PIXELS (V_PIXELS)
  ) u_raster (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .clear_in   (rc_clear),
    .advance_in (issue),
    .x_out      (rc_x),
    .y_out      (rc_y),
    .last_out   (rc_last)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= StIdle;
      inflight_q <= '0;
      x_q        <= '0;
      y_q        <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      snap_x_q   <= '0;
      snap_y_q   <= '0;
      snap_z_q   <= '0;
    end else begin
      inflight_q <= inflight_d;
      valid_q    <= issue;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
      if (issue) begin
        x_q <= rc_x;
        y_q <= rc_y;
      end
      unique case (state_q)
        StIdle: begin
          if (frame_start_in) begin
            state_q <= StLatch;
          end else begin
            busy_q <= 1'b0;
          end
        end
        StLatch: begin
          snap_x_q <= block_x_live_in;
          snap_y_q <= block_y_live_in;
          snap_z_q <= block_z_live_in;
          // Only a 1x1 frame finishes its raster inside LATCH.
          state_q  <= (issue && rc_last) ? StDrain : StScan;
        end
        StScan: begin
          if (issue && rc_last) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (inflight_q == '0) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef RAY_SCHED_STALL_COUNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      stall_q <= '0;
    end else if (state_q == StLatch) begin
      stall_q <= '0;
    end else if ((state_q == StScan) && !issue && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles_out = stall_q;
`else
  assign stall_cycles_out = '0;
`endif

  assign x_out          = x_q;
  assign y_out          = y_q;
  assign valid_out      = valid_q;
  assign busy_out       = busy_q;
  assign frame_done_out = done_q;
  assign block_x_out    = snap_x_q;
  assign block_y_out    = snap_y_q;
  assign block_z_out    = snap_z_q;

endmodule

// File: tb/tb_ray_pixel_scheduler.sv
// Directed bench: a 4x2 frame with delayed credits and snapshot hold, plus a 4x2 frame
// with two credits exercising stalls, same-cycle return, spurious return and reset.
module tb_ray_pixel_scheduler;

  localparam int NB = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, fs_a, fs_b, cr_a, cr_b;
  logic [NB-1:0][11:0] bx_live, by_live;
  logic [NB-1:0][13:0] bz_live;

  logic [10:0] x_a, x_b;
  logic [9:0]  y_a, y_b;
  logic        valid_a, valid_b, busy_a, busy_b, done_a, done_b;
  logic [31:0] stall_a, stall_b;
  logic [NB-1:0][11:0] bxo_a, byo_a, bxo_b, byo_b;
  logic [NB-1:0][13:0] bzo_a, bzo_b;

  int n_tests = 0;
  int n_fail  = 0;

  ray_pixel_scheduler #(
    .H_PIXELS     (4),
    .V_PIXELS     (2),
    .NUM_BLOCKS   (NB),
    .MAX_INFLIGHT (64)
  ) dut_a (
    .clk_in           (clk),
    .rst_in           (rst_a),
    .frame_start_in   (fs_a),
    .block_x_live_in  (bx_live),
    .block_y_live_in  (by_live),
    .block_z_live_in  (bz_live),
    .credit_return_in (cr_a),
    .x_out            (x_a),
    .y_out            (y_a),
    .valid_out        (valid_a),
    .block_x_out      (bxo_a),
    .block_y_out      (byo_a),
    .block_z_out      (bzo_a),
    .busy_out         (busy_a),
    .frame_done_out   (done_a),
    .stall_cycles_out (stall_a)
  );

  ray_pixel_scheduler #(
    .H_PIXELS     (4),
    .V_PIXELS     (2),
    .NUM_BLOCKS   (NB),
    .MAX_INFLIGHT (2)
  ) dut_b (
    .clk_in           (clk),
    .rst_in           (rst_b),
    .frame_start_in   (fs_b),
    .block_x_live_in  (bx_live),
    .block_y_live_in  (by_live),
    .block_z_live_in  (bz_live),
    .credit_return_in (cr_b),
    .x_out            (x_b),
    .y_out            (y_b),
    .valid_out        (valid_b),
    .block_x_out      (bxo_b),
    .block_y_out      (byo_b),
    .block_z_out      (bzo_b),
    .busy_out         (busy_b),
    .frame_done_out   (done_b),
    .stall_cycles_out (stall_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int stall_exp(input int n);
`ifdef RAY_SCHED_STALL_COUNT_EN
    return n;
`else
    return 0;
`endif
  endfunction

  // Runs one 4x2 frame on dut_a; each credit comes back 3 cycles after its pixel.
  task automatic frame_a(input string tag, input int fs_again, input logic [13:0] z_before,
                         input logic [13:0] z_after);
    logic [3:0] sh;
    int n_iss, n_done, done_c;
    sh = '0;
    n_iss = 0;
    n_done = 0;
    done_c = -1;
    fs_a = 1'b1;
    tick();
    fs_a = 1'b0;
    check_eq({tag, "_latch_busy"}, busy_a, 1);
    check_eq({tag, "_latch_valid"}, valid_a, 0);
    check_eq({tag, "_z_before_latch"}, bzo_a[0], z_before);
    for (int c = 0; c < 16; c++) begin
      tick();
      sh = sh >> 1;
      bz_live[0] = 14'd2900;
      fs_a = (c == fs_again);
      if (valid_a) begin
        check_eq({tag, "_issue_cycle"}, c, n_iss);
        check_eq({tag, "_x"}, x_a, n_iss % 4);
        check_eq({tag, "_y"}, y_a, n_iss / 4);
        n_iss++;
        sh[3] = 1'b1;
      end
      if (done_a) begin
        n_done++;
        done_c = c;
      end
      if (c == 0 || c == 9) check_eq({tag, "_z_snapshot"}, bzo_a[0], z_after);
      cr_a = sh[0];
    end
    fs_a = 1'b0;
    cr_a = 1'b0;
    check_eq({tag, "_issue_count"}, n_iss, 8);
    check_eq({tag, "_done_count"}, n_done, 1);
    check_eq({tag, "_done_cycle"}, done_c, 12);
    check_eq({tag, "_idle_busy"}, busy_a, 0);
    check_eq({tag, "_hold_x"}, x_a, 3);
    check_eq({tag, "_hold_y"}, y_a, 1);
  endtask

  initial begin
    int iss_c[4];
    int nb;
    rst_a = 1'b1;
    rst_b = 1'b1;
    fs_a = 1'b0;
    fs_b = 1'b0;
    cr_a = 1'b0;
    cr_b = 1'b0;
    bx_live = '0;
    by_live = '0;
    bz_live = '0;
    tick();
    tick();
    rst_a = 1'b0;
    rst_b = 1'b0;
    check_eq("rst_valid", valid_a, 0);
    check_eq("rst_busy", busy_a, 0);
    check_eq("rst_done", done_a, 0);
    check_eq("rst_xy", {x_a, y_a}, 0);
    check_eq("rst_stall", stall_b, 0);

    bx_live[1] = 12'hABC;
    by_live[2] = 12'h123;
    bz_live[0] = 14'd3000;
    tick();

    frame_a("a1", -1, 14'd0, 14'd3000);
    check_eq("a1_y_snapshot", byo_a[2], 12'h123);
    frame_a("a2", 2, 14'd3000, 14'd2900);

    // dut_b: two credits, no returns until cycle 9, then single returns at 9 and 12.
    iss_c = '{0, 1, 10, 13};
    nb = 0;
    fs_b = 1'b1;
    tick();
    fs_b = 1'b0;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (valid_b) begin
        if (nb < 4) check_eq("b1_issue_cycle", c, iss_c[nb]);
        check_eq("b1_x", x_b, nb);
        check_eq("b1_y", y_b, 0);
        nb++;
      end
      if (c == 0) check_eq("b1_x_snapshot", bxo_b[1], 12'hABC);
      if (c == 9) check_eq("b1_stall_9", stall_b, stall_exp(8));
      if (c == 15) check_eq("b1_stall_15", stall_b, stall_exp(12));
      if (c == 8) check_eq("b1_stalled_count", nb, 2);
      cr_b = (c == 9) || (c == 12);
    end
    check_eq("b1_issue_count", nb, 4);

    // Reset mid-SCAN.
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    check_eq("b_rst_valid", valid_b, 0);
    check_eq("b_rst_busy", busy_b, 0);
    check_eq("b_rst_xy", {x_b, y_b}, 0);
    check_eq("b_rst_stall", stall_b, 0);
    check_eq("b_rst_snapshot", bxo_b[1], 0);
    check_eq("b_rst_done", done_b, 0);

    // Spurious return while idle with nothing in flight.
    cr_b = 1'b1;
    tick();
    cr_b = 1'b0;
    check_eq("b_spurious_busy", busy_b, 0);
    check_eq("b_spurious_done", done_b, 0);

    // Return together with the issue at inflight 1: counter holds, so three pixels fit.
    iss_c = '{0, 1, 2, -1};
    nb = 0;
    fs_b = 1'b1;
    tick();
    fs_b = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (valid_b) begin
        if (nb < 3) check_eq("b2_issue_cycle", c, iss_c[nb]);
        check_eq("b2_x", x_b, nb);
        check_eq("b2_y", y_b, 0);
        nb++;
      end
      if (c == 9) check_eq("b2_stall", stall_b, stall_exp(7));
      cr_b = (c == 0);
    end
    check_eq("b2_issue_count", nb, 3);
    check_eq("b2_busy", busy_b, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
